game_ctrl: RTL and testbench



---
 rtl/game_ctrl_if.sv | 28 ++
 rtl/game_ctrl.sv | 127 ++++++++++++
 tb/tb_game_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/game_ctrl_if.sv
// Breakout sequencer bus: ball-engine/keyboard inputs and game status outputs.
// The master side is the ball engine/keyboard. The slave side is game_ctrl.
interface game_ctrl_if #(
   parameter int NUM_BLOCKS = 32
) ();

   logic [7:0]            keycode;
   logic [NUM_BLOCKS-1:0] Blocks;
   logic [1:0]            lives;
   logic                  Bar_Reset;
   logic                  Game_Reset;
   logic [1:0]            state;
   logic [15:0]           score;
   logic [15:0]           hi_score;
   logic                  banner_on;
   logic                  life_lost;

   modport master (
      output keycode, Blocks, lives, Bar_Reset,
      input  Game_Reset, state, score, hi_score, banner_on, life_lost
   );

   modport slave (
      input  keycode, Blocks, lives, Bar_Reset,
      output Game_Reset, state, score, hi_score, banner_on, life_lost
   );

endinterface

// File: rtl/game_ctrl.sv
// Breakout game sequencer. It turns the ball-engine bitmap and lives into game
// state, a saturating score, a high score and a one-frame restart pulse.
module game_ctrl #(
   parameter int         NUM_BLOCKS    = 32,
   parameter int         PTS_PER_BLOCK = 10,
   parameter int         BANNER_FRAMES = 120,
   parameter logic [7:0] START_KEY     = 8'h2c,
   parameter logic [7:0] RESTART_KEY   = 8'h28
) (
   input  logic        frame_clk,
   input  logic        Reset,
   game_ctrl_if.slave  bus
);

   localparam int CNT_W = $clog2(BANNER_FRAMES + 1);
   localparam int PC_W  = $clog2(NUM_BLOCKS + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2,
      WIN  = 2'd3
   } state_t;

   state_t                state_q, state_next;
   logic [15:0]           score_q, score_next;
   logic [15:0]           hi_q, hi_next;
   logic [CNT_W-1:0]      cnt_q, cnt_next;
   logic [NUM_BLOCKS-1:0] prev_blocks_q, prev_blocks_next;
   logic [7:0]            prev_key_q;
   logic                  game_reset_q, game_reset_next;
   logic                  life_lost_q, life_lost_next;
   logic                  banner_q, banner_next;

   logic [NUM_BLOCKS-1:0] cleared;
   logic [PC_W-1:0]       cleared_cnt;
   logic [31:0]           score_sum;
   logic [15:0]           score_play;
   logic                  start_hit, restart_hit, banner_done;

   function automatic logic [PC_W-1:0] popcount(input logic [NUM_BLOCKS-1:0] v);
      logic [PC_W-1:0] c;
      c = '0;
      for (int i = 0; i < NUM_BLOCKS; i++) c = c + PC_W'(v[i]);
      return c;
   endfunction

   // A key counts only on the frame it first appears, so holding it fires once.
   assign start_hit   = (bus.keycode == START_KEY)   && (prev_key_q != START_KEY);
   assign restart_hit = (bus.keycode == RESTART_KEY) && (prev_key_q != RESTART_KEY);
   assign banner_done = (cnt_q == CNT_W'(BANNER_FRAMES));

   assign cleared     = prev_blocks_q & ~bus.Blocks;
   assign cleared_cnt = popcount(cleared);
   assign score_sum   = 32'(score_q) + 32'(PTS_PER_BLOCK) * 32'(cleared_cnt);
   assign score_play  = (score_sum > 32'h0000_FFFF) ? 16'hFFFF : score_sum[15:0];

   always_comb begin
      state_next       = state_q;
      score_next       = score_q;
      hi_next          = hi_q;
      cnt_next         = cnt_q;
      prev_blocks_next = prev_blocks_q;
      game_reset_next  = 1'b0;
      life_lost_next   = 1'b0;
      case (state_q)
         IDLE: begin
            prev_blocks_next = bus.Blocks;
            if (start_hit) state_next = PLAY;
         end
         PLAY: begin
            score_next       = score_play;
            prev_blocks_next = bus.Blocks;
            life_lost_next   = bus.Bar_Reset;
            // The final frame's points are folded into the high score on exit.
            if (bus.Blocks == '0 || bus.lives == 2'd0) begin
               state_next = (bus.Blocks == '0) ? WIN : OVER;
               hi_next    = (score_play > hi_q) ? score_play : hi_q;
               cnt_next   = '0;
            end
         end
         OVER, WIN: begin
            if (restart_hit && banner_done) begin
               game_reset_next = 1'b1;
               score_next      = 16'd0;
               state_next      = IDLE;
            end else if (!banner_done) begin
               cnt_next = cnt_q + CNT_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
      banner_next = (state_next == OVER) || (state_next == WIN);
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_q       <= IDLE;
         score_q       <= 16'd0;
         hi_q          <= 16'd0;
         cnt_q         <= '0;
         prev_blocks_q <= '0;
         prev_key_q    <= 8'd0;
         game_reset_q  <= 1'b0;
         life_lost_q   <= 1'b0;
         banner_q      <= 1'b0;
      end else begin
         state_q       <= state_next;
         score_q       <= score_next;
         hi_q          <= hi_next;
         cnt_q         <= cnt_next;
         prev_blocks_q <= prev_blocks_next;
         prev_key_q    <= bus.keycode;
         game_reset_q  <= game_reset_next;
         life_lost_q   <= life_lost_next;
         banner_q      <= banner_next;
      end
   end

   assign bus.state      = state_q;
   assign bus.score      = score_q;
   assign bus.hi_score   = hi_q;
   assign bus.Game_Reset = game_reset_q;
   assign bus.life_lost  = life_lost_q;
   assign bus.banner_on  = banner_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: a table of frame vectors for the first game,
// then hand-written banner timing, saturation/WIN priority and mid-game reset.
module tb_game_ctrl;

   localparam logic [31:0] ALL = 32'hFFFF_FFFF;

   typedef struct {
      logic [7:0]  key;
      logic [31:0] blocks;
      logic [1:0]  lives;
      logic        barReset;
      logic [1:0]  expState;
      logic [15:0] expScore;
      logic [15:0] expHi;
      logic        expLifeLost;
      logic        expBanner;
   } vec_t;

   logic frameClk;
   logic reset;
   int   checks;
   int   errors;
   int   expScore;
   vec_t vecs[20];

   game_ctrl_if #(.NUM_BLOCKS(32)) bus ();

   game_ctrl #(
      .NUM_BLOCKS(32), .PTS_PER_BLOCK(10), .BANNER_FRAMES(120),
      .START_KEY(8'h2c), .RESTART_KEY(8'h28)
   ) dut (
      .frame_clk(frameClk),
      .Reset(reset),
      .bus(bus)
   );

   initial frameClk = 1'b0;
   always #5 frameClk = ~frameClk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic checkAll(input string tag, input logic [1:0] st, input logic [15:0] sc,
                           input logic [15:0] hi, input logic ll, input logic ban, input logic gr);
      checkOutput({tag, ".state"},      32'(bus.state),      32'(st));
      checkOutput({tag, ".score"},      32'(bus.score),      32'(sc));
      checkOutput({tag, ".hi_score"},   32'(bus.hi_score),   32'(hi));
      checkOutput({tag, ".life_lost"},  32'(bus.life_lost),  32'(ll));
      checkOutput({tag, ".banner_on"},  32'(bus.banner_on),  32'(ban));
      checkOutput({tag, ".Game_Reset"}, 32'(bus.Game_Reset), 32'(gr));
   endtask

   task automatic applyStimulus(input logic [7:0] key, input logic [31:0] blocks,
                                input logic [1:0] lives, input logic barReset);
      @(negedge frameClk);
      bus.keycode   = key;
      bus.Blocks    = blocks;
      bus.lives     = lives;
      bus.Bar_Reset = barReset;
      @(posedge frameClk);
      #1;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      expScore = 0;

      // Game 1: start, scoring, reappearing block, three lost lives into OVER.
      vecs[0]  = '{8'h00, ALL, 2'd3, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0, 1'b0};
      vecs[1]  = '{8'h2c, ALL, 2'd3, 1'b0, 2'd1, 16'd0, 16'd0, 1'b0, 1'b0};
      for (int i = 2; i < 12; i++)
         vecs[i] = '{8'h2c, ALL, 2'd3, 1'b0, 2'd1, 16'd0, 16'd0, 1'b0, 1'b0};
      vecs[12] = '{8'h00, ALL & ~32'h0000_0020, 2'd3, 1'b0, 2'd1, 16'd10, 16'd0, 1'b0, 1'b0};
      vecs[13] = '{8'h00, ALL & ~32'h0000_01E0, 2'd3, 1'b0, 2'd1, 16'd40, 16'd0, 1'b0, 1'b0};
      vecs[14] = '{8'h00, ALL & ~32'h0000_01C0, 2'd3, 1'b0, 2'd1, 16'd40, 16'd0, 1'b0, 1'b0};
      vecs[15] = '{8'h00, ALL & ~32'h0000_01C0, 2'd2, 1'b1, 2'd1, 16'd40, 16'd0, 1'b1, 1'b0};
      vecs[16] = '{8'h00, ALL & ~32'h0000_01C0, 2'd2, 1'b0, 2'd1, 16'd40, 16'd0, 1'b0, 1'b0};
      vecs[17] = '{8'h00, ALL & ~32'h0000_01C0, 2'd1, 1'b1, 2'd1, 16'd40, 16'd0, 1'b1, 1'b0};
      vecs[18] = '{8'h00, ALL & ~32'h0000_01C0, 2'd1, 1'b0, 2'd1, 16'd40, 16'd0, 1'b0, 1'b0};
      vecs[19] = '{8'h00, ALL & ~32'h0000_01C0, 2'd0, 1'b1, 2'd2, 16'd40, 16'd40, 1'b1, 1'b1};

      reset         = 1'b1;
      bus.keycode   = 8'h00;
      bus.Blocks    = ALL;
      bus.lives     = 2'd3;
      bus.Bar_Reset = 1'b0;
      #7;
      checkAll("reset", 2'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
      @(negedge frameClk);
      reset = 1'b0;

      for (int i = 0; i < 20; i++) begin
         applyStimulus(vecs[i].key, vecs[i].blocks, vecs[i].lives, vecs[i].barReset);
         checkAll($sformatf("vec%0d", i), vecs[i].expState, vecs[i].expScore, vecs[i].expHi,
                  vecs[i].expLifeLost, 1'b0 ^ vecs[i].expBanner, 1'b0);
      end

      // OVER banner: inputs other than keycode are ignored; early presses are dropped.
      for (int i = 0; i < 50; i++) begin
         applyStimulus(8'h00, $urandom, 2'($urandom_range(0, 3)), 1'(i % 2));
         checkAll($sformatf("over%0d", i), 2'd2, 16'd40, 16'd40, 1'b0, 1'b1, 1'b0);
      end
      applyStimulus(8'h28, ALL, 2'd3, 1'b0);
      checkAll("early50", 2'd2, 16'd40, 16'd40, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 68; i++) begin
         applyStimulus(8'h00, ALL, 2'd3, 1'b0);
         checkAll($sformatf("wait%0d", i), 2'd2, 16'd40, 16'd40, 1'b0, 1'b1, 1'b0);
      end
      applyStimulus(8'h28, ALL, 2'd3, 1'b0);
      checkAll("early119", 2'd2, 16'd40, 16'd40, 1'b0, 1'b1, 1'b0);
      applyStimulus(8'h00, ALL, 2'd3, 1'b0);
      checkAll("sat120", 2'd2, 16'd40, 16'd40, 1'b0, 1'b1, 1'b0);
      applyStimulus(8'h28, ALL, 2'd3, 1'b0);
      checkAll("restart", 2'd0, 16'd0, 16'd40, 1'b0, 1'b0, 1'b1);
      applyStimulus(8'h00, ALL, 2'd3, 1'b1);
      checkAll("afterGR", 2'd0, 16'd0, 16'd40, 1'b0, 1'b0, 1'b0);

      // Game 2: pump score to 65530, saturate, then WIN beats OVER.
      applyStimulus(8'h2c, ALL, 2'd3, 1'b0);
      checkAll("start2", 2'd1, 16'd0, 16'd40, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 211; i++) begin
         applyStimulus(8'h00, 32'h0000_0001, 2'd3, 1'b0);
         expScore += 310;
         checkAll($sformatf("pumpClr%0d", i), 2'd1, 16'(expScore), 16'd40, 1'b0, 1'b0, 1'b0);
         applyStimulus(8'h00, ALL, 2'd3, 1'b0);
         checkAll($sformatf("pumpSet%0d", i), 2'd1, 16'(expScore), 16'd40, 1'b0, 1'b0, 1'b0);
      end
      applyStimulus(8'h00, ALL & ~32'h0000_1FFE, 2'd3, 1'b0);
      checkAll("score65530", 2'd1, 16'd65530, 16'd40, 1'b0, 1'b0, 1'b0);
      applyStimulus(8'h00, ALL & ~32'h0000_3FFE, 2'd3, 1'b0);
      checkAll("saturate", 2'd1, 16'hFFFF, 16'd40, 1'b0, 1'b0, 1'b0);
      applyStimulus(8'h00, 32'h0000_0000, 2'd0, 1'b0);
      checkAll("winPrio", 2'd3, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 60; i++) applyStimulus(8'h00, ALL, 2'd3, 1'b0);
      checkAll("win60", 2'd3, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0);

      // Asynchronous reset between clock edges while the WIN banner is up.
      #2;
      reset = 1'b1;
      #1;
      checkAll("asyncRst", 2'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
      @(negedge frameClk);
      reset = 1'b0;
      applyStimulus(8'h00, ALL, 2'd3, 1'b0);
      checkAll("postRst", 2'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
